ddr3_rw_arb: RTL and testbench

Arbiter and burst sequencer that shares one DDR3 AXI port between the write command controller and the read command controller. It takes "burst ready" requests from the write-side and read-side FIFOs and grants them round-robin. For each grant it drives a single fixed-length burst command (address, len, id, ap, enable), holds it until the owning controller returns its done pulse, then advances that channel's address pointer inside a wrapping frame window. It sits between the video/stream FIFOs and the DDR3 read/write control blocks.

---
 rtl/ddr3_rw_arb.sv | 173 +++++++++++++++++
 tb/tb_ddr3_rw_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_rw_arb.sv
// Round-robin arbiter and burst sequencer sharing one DDR3 AXI command port between write and read.
// Command outputs are registered images of the FSM state, so they trail each state change by one cycle.
module ddr3_rw_arb #(
    parameter int unsigned                CTRL_ADDR_WIDTH = 28,
    parameter int unsigned                MEM_SPACE_AW    = 18,
    parameter int unsigned                BURST_LEN       = 16,
    parameter logic [CTRL_ADDR_WIDTH-1:0] WR_BASE         = 28'h0000000,
    parameter logic [CTRL_ADDR_WIDTH-1:0] RD_BASE         = 28'h0000000,
    parameter int unsigned                TIMEOUT         = 1023
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_req,
    input  logic                       rd_req,
    input  logic                       frame_sync,
    output logic                       write_en,
    output logic [CTRL_ADDR_WIDTH-1:0] ddr3_wr_addr,
    input  logic                       write_done_p,
    output logic                       read_en,
    output logic [CTRL_ADDR_WIDTH-1:0] ddr3_rd_addr,
    input  logic                       read_done_p,
    output logic [3:0]                 ddr3_axi_len,
    output logic [3:0]                 ddr3_axi_id,
    output logic                       ddr3_axi_ap,
    output logic                       busy,
    output logic [15:0]                wr_burst_cnt,
    output logic [15:0]                rd_burst_cnt,
    output logic                       err_flag
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;
    typedef enum logic {G_WR, G_RD} grant_t;

    localparam int unsigned             WD_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]         WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [MEM_SPACE_AW-1:0] PTR_STEP = MEM_SPACE_AW'(BURST_LEN * 8);
    localparam logic [3:0]              AXI_LEN  = 4'(BURST_LEN - 1);

    state_t                      state_q, state_d;
    grant_t                      last_grant_q, last_grant_d;
    logic                        sync_pend_q, sync_pend_d;
    logic [MEM_SPACE_AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WD_W-1:0]             wdog_q, wdog_d;
    logic                        err_q, err_d;
    logic                        wr_fin_q, wr_fin_d, rd_fin_q, rd_fin_d;
    logic [15:0]                 wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic                        write_en_q, write_en_d, read_en_q, read_en_d;
    logic                        busy_q, busy_d;
    logic [3:0]                  id_q, id_d;
    logic [CTRL_ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;

    // NOTE: every register, memory-free datapath included, takes its reset value asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= G_RD;
            sync_pend_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wdog_q       <= '0;
            err_q        <= 1'b0;
            wr_fin_q     <= 1'b0;
            rd_fin_q     <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            write_en_q   <= 1'b0;
            read_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            id_q         <= '0;
            wr_addr_q    <= WR_BASE;
            rd_addr_q    <= RD_BASE;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sync_pend_q  <= sync_pend_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wdog_q       <= wdog_d;
            err_q        <= err_d;
            wr_fin_q     <= wr_fin_d;
            rd_fin_q     <= rd_fin_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            write_en_q   <= write_en_d;
            read_en_q    <= read_en_d;
            busy_q       <= busy_d;
            id_q         <= id_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
        end
    end

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sync_pend_d  = sync_pend_q | frame_sync;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        wdog_d       = wdog_q + WD_W'(1);
        err_d        = err_q;
        wr_fin_d     = 1'b0;
        rd_fin_d     = 1'b0;
        wr_cnt_d     = wr_cnt_q + 16'(wr_fin_q);
        rd_cnt_d     = rd_cnt_q + 16'(rd_fin_q);

        unique case (state_q)
            S_IDLE: begin
                wdog_d = '0;
                if (sync_pend_q) begin
                    // Rewind takes the whole idle cycle; a frame_sync arriving now stays pending.
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    sync_pend_d = frame_sync;
                end else if (wr_req && (!rd_req || last_grant_q == G_RD)) begin
                    state_d = S_WR;
                end else if (rd_req) begin
                    state_d = S_RD;
                end
            end
            S_WR: begin
                if (write_done_p) begin
                    state_d      = S_IDLE;
                    wr_ptr_d     = wr_ptr_q + PTR_STEP;
                    wr_fin_d     = 1'b1;
                    last_grant_d = G_WR;
                end else if (wdog_q == WD_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_RD: begin
                if (read_done_p) begin
                    state_d      = S_IDLE;
                    rd_ptr_d     = rd_ptr_q + PTR_STEP;
                    rd_fin_d     = 1'b1;
                    last_grant_d = G_RD;
                end else if (wdog_q == WD_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        write_en_d = (state_q == S_WR);
        read_en_d  = (state_q == S_RD);
        busy_d     = (state_q != S_IDLE);
        id_d       = id_q;
        if (state_q == S_WR) begin
            id_d = 4'd0;
        end else if (state_q == S_RD) begin
            id_d = 4'd1;
        end
        wr_addr_d = WR_BASE + CTRL_ADDR_WIDTH'(wr_ptr_q);
        rd_addr_d = RD_BASE + CTRL_ADDR_WIDTH'(rd_ptr_q);
    end

    assign write_en     = write_en_q;
    assign read_en      = read_en_q;
    assign busy         = busy_q;
    assign ddr3_axi_id  = id_q;
    assign ddr3_wr_addr = wr_addr_q;
    assign ddr3_rd_addr = rd_addr_q;
    assign wr_burst_cnt = wr_cnt_q;
    assign rd_burst_cnt = rd_cnt_q;
    assign err_flag     = err_q;
    assign ddr3_axi_len = AXI_LEN;
    assign ddr3_axi_ap  = 1'b0;

endmodule

// File: tb/tb_ddr3_rw_arb.sv
// Directed bench for ddr3_rw_arb: grant latency, round-robin, window wrap, frame rewind, watchdog, reset.
module tb_ddr3_rw_arb;

    localparam logic [27:0] WB = 28'h0001000;
    localparam logic [27:0] RB = 28'h0200000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req = 1'b0, rd_req = 1'b0, frame_sync = 1'b0;
    logic        write_done_p = 1'b0, read_done_p = 1'b0;
    logic        write_en, read_en, ddr3_axi_ap, busy, err_flag;
    logic [27:0] ddr3_wr_addr, ddr3_rd_addr;
    logic [3:0]  ddr3_axi_len, ddr3_axi_id;
    logic [15:0] wr_burst_cnt, rd_burst_cnt;

    int checks = 0;
    int errors = 0;

    ddr3_rw_arb #(
        .CTRL_ADDR_WIDTH(28),
        .MEM_SPACE_AW   (9),
        .BURST_LEN      (16),
        .WR_BASE        (WB),
        .RD_BASE        (RB),
        .TIMEOUT        (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .frame_sync  (frame_sync),
        .write_en    (write_en),
        .ddr3_wr_addr(ddr3_wr_addr),
        .write_done_p(write_done_p),
        .read_en     (read_en),
        .ddr3_rd_addr(ddr3_rd_addr),
        .read_done_p (read_done_p),
        .ddr3_axi_len(ddr3_axi_len),
        .ddr3_axi_id (ddr3_axi_id),
        .ddr3_axi_ap (ddr3_axi_ap),
        .busy        (busy),
        .wr_burst_cnt(wr_burst_cnt),
        .rd_burst_cnt(rd_burst_cnt),
        .err_flag    (err_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0; frame_sync = 1'b0;
        write_done_p = 1'b0; read_done_p = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_any(input string tag);
        int n = 0;
        while (!(write_en || read_en) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(write_en | read_en), 32'd1);
    endtask

    // Controller model: wait for the grant, check it, answer with a one-cycle done pulse.
    task automatic do_burst(input bit exp_rd, input logic [27:0] exp_addr, input bit drop);
        wait_any("grant_seen");
        check("grant_rd", 32'(read_en), 32'(exp_rd));
        check("grant_wr", 32'(write_en), 32'(!exp_rd));
        check("burst_addr", 32'(exp_rd ? ddr3_rd_addr : ddr3_wr_addr), 32'(exp_addr));
        check("burst_id", 32'(ddr3_axi_id), 32'(exp_rd));
        if (exp_rd) read_done_p = 1'b1; else write_done_p = 1'b1;
        if (drop) begin
            wr_req = 1'b0;
            rd_req = 1'b0;
        end
        @(negedge clk);
        read_done_p = 1'b0;
        write_done_p = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int hi;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(write_en), 32'd0);
        check("rst_rd_en", 32'(read_en), 32'd0);
        check("rst_wr_addr", 32'(ddr3_wr_addr), 32'(WB));
        check("rst_rd_addr", 32'(ddr3_rd_addr), 32'(RB));
        check("rst_id", 32'(ddr3_axi_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnts", {wr_burst_cnt, rd_burst_cnt}, 32'd0);
        check("rst_err", 32'(err_flag), 32'd0);
        check("axi_len", 32'(ddr3_axi_len), 32'd15);
        check("axi_ap", 32'(ddr3_axi_ap), 32'd0);

        // Single write: enable one cycle after the grant, then pointer/count update.
        apply_reset();
        wr_req = 1'b1;
        @(negedge clk);
        check("wr_lat0", 32'(write_en), 32'd0);
        @(negedge clk);
        check("wr_lat1", 32'(write_en), 32'd1);
        check("wr_addr0", 32'(ddr3_wr_addr), 32'(WB));
        check("wr_id0", 32'(ddr3_axi_id), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        write_done_p = 1'b1;
        wr_req = 1'b0;
        @(negedge clk);
        write_done_p = 1'b0;
        check("wr_hold", 32'(write_en), 32'd1);
        @(negedge clk);
        check("wr_drop", 32'(write_en), 32'd0);
        check("wr_idle", 32'(busy), 32'd0);
        check("wr_cnt1", 32'(wr_burst_cnt), 32'd1);
        check("wr_ptr128", 32'(ddr3_wr_addr), 32'(WB + 28'd128));

        // Both requests held: W,R,W,R,W,R.
        apply_reset();
        wr_req = 1'b1;
        rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_burst(i % 2 == 1, ((i % 2 == 1) ? RB : WB) + 28'(128 * (i / 2)), i == 5);
        end
        check("rr_wr_cnt", 32'(wr_burst_cnt), 32'd3);
        check("rr_rd_cnt", 32'(rd_burst_cnt), 32'd3);

        // Read window wrap: 512-address window, 128-address steps.
        apply_reset();
        rd_req = 1'b1;
        do_burst(1'b1, RB + 28'd0, 1'b0);
        do_burst(1'b1, RB + 28'd128, 1'b0);
        do_burst(1'b1, RB + 28'd256, 1'b0);
        do_burst(1'b1, RB + 28'd384, 1'b0);
        do_burst(1'b1, RB + 28'd0, 1'b1);
        check("wrap_rd_cnt", 32'(rd_burst_cnt), 32'd5);

        // frame_sync during a write burst.
        apply_reset();
        wr_req = 1'b1;
        do_burst(1'b0, WB, 1'b1);
        rd_req = 1'b1;
        do_burst(1'b1, RB, 1'b1);
        wr_req = 1'b1;
        wait_any("fs_grant");
        check("fs_addr", 32'(ddr3_wr_addr), 32'(WB + 28'd128));
        frame_sync = 1'b1;
        wr_req = 1'b0;
        @(negedge clk);
        frame_sync = 1'b0;
        read_done_p = 1'b1;
        @(negedge clk);
        read_done_p = 1'b0;
        @(negedge clk);
        check("fs_inflight", 32'(write_en), 32'd1);
        check("fs_rd_ignored", 32'(rd_burst_cnt), 32'd1);
        write_done_p = 1'b1;
        @(negedge clk);
        write_done_p = 1'b0;
        @(negedge clk);
        check("fs_ptr256", 32'(ddr3_wr_addr), 32'(WB + 28'd256));
        check("fs_wr_cnt", 32'(wr_burst_cnt), 32'd2);
        @(negedge clk);
        check("fs_rewind_wr", 32'(ddr3_wr_addr), 32'(WB));
        check("fs_rewind_rd", 32'(ddr3_rd_addr), 32'(RB));
        rd_req = 1'b1;
        do_burst(1'b1, RB, 1'b1);
        wr_req = 1'b1;
        do_burst(1'b0, WB, 1'b1);

        // Watchdog: no done pulse, then a retry at the same address.
        apply_reset();
        wr_req = 1'b1;
        do_burst(1'b0, WB, 1'b1);
        wr_req = 1'b1;
        wait_any("wd_grant");
        wr_req = 1'b0;
        hi = 0;
        while (write_en && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        check("wd_en_cycles", 32'(hi), 32'd15);
        check("wd_err", 32'(err_flag), 32'd1);
        check("wd_busy", 32'(busy), 32'd0);
        check("wd_cnt_kept", 32'(wr_burst_cnt), 32'd1);
        wr_req = 1'b1;
        do_burst(1'b0, WB + 28'd128, 1'b1);
        check("wd_retry_cnt", 32'(wr_burst_cnt), 32'd2);
        check("wd_err_sticky", 32'(err_flag), 32'd1);

        // Reset asserted mid-read.
        apply_reset();
        rd_req = 1'b1;
        do_burst(1'b1, RB, 1'b0);
        wait_any("mr_grant");
        check("mr_addr", 32'(ddr3_rd_addr), 32'(RB + 28'd128));
        #2;
        rst_n = 1'b0;
        rd_req = 1'b0;
        #1;
        check("mr_rd_en", 32'(read_en), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_cnt", 32'(rd_burst_cnt), 32'd0);
        check("mr_addr_rst", 32'(ddr3_rd_addr), 32'(RB));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_done_p = 1'b1;
        @(negedge clk);
        read_done_p = 1'b0;
        repeat (2) @(negedge clk);
        check("mr_idle_done_cnt", 32'(rd_burst_cnt), 32'd0);
        check("mr_idle_done_addr", 32'(ddr3_rd_addr), 32'(RB));
        check("mr_idle_en", 32'(read_en), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
